// File: rtl/udp_sc_frame_mux_if.sv
// udp_sc_frame_mux_if: source-side and frame-FIFO-side bundle for the
// slow-control UDP framer. master = framer, slave = sources/FIFO.
`timescale 1ns/1ps
interface udp_sc_frame_mux_if #(
  parameter int NCH = 4,
  parameter int CW  = 2
);
  logic [NCH-1:0]    src_req;
  logic [16*NCH-1:0] src_len;
  logic [16*NCH-1:0] src_sport;
  logic [16*NCH-1:0] src_dport;
  logic [8*NCH-1:0]  src_data;
  logic [NCH-1:0]    src_valid;
  logic [NCH-1:0]    src_rd;
  logic [NCH-1:0]    src_ack;
  logic [NCH-1:0]    src_done;
  logic [NCH-1:0]    src_err;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [7:0]        fifo_data;
  logic              fifo_data_valid;
  logic              fifo_good_frame;
  logic              fifo_bad_frame;
  logic              busy;
  logic [CW-1:0]     chan_sel;

  modport master (
    input  src_req, src_len, src_sport, src_dport,
    input  src_data, src_valid, fifo_full,
    output src_rd, src_ack, src_done, src_err,
    output fifo_wr_en, fifo_data, fifo_data_valid,
    output fifo_good_frame, fifo_bad_frame,
    output busy, chan_sel
  );

  modport slave (
    output src_req, src_len, src_sport, src_dport,
    output src_data, src_valid, fifo_full,
    input  src_rd, src_ack, src_done, src_err,
    input  fifo_wr_en, fifo_data, fifo_data_valid,
    input  fifo_good_frame, fifo_bad_frame,
    input  busy, chan_sel
  );
endinterface

// File: rtl/udp_sc_frame_mux.sv
// udp_sc_frame_mux: round-robin N-channel slow-control UDP framer.
// Prefixes each granted payload with a 10-byte len/UDP header.
// Ports: clk125m, reset_n (async active-low), bus (master modport):
//   src_* per-channel request/len/ports/data handshake,
//   fifo_* 8-bit frame-FIFO write port, busy, chan_sel.
// Optional: define UDP_SC_TIMEOUT_EN for the source idle timeout
// that aborts a frame with fifo_bad_frame.
`timescale 1ns/1ps
module udp_sc_frame_mux #(
  parameter int          NCH        = 4,
  parameter int          CW         = 2,
  parameter logic [15:0] MAX_LEN    = 16'd1472,
  parameter logic [15:0] UDP_CHKSUM = 16'h0000,
  parameter int          GAP_CYCLES = 4,
  parameter logic [15:0] TIMEOUT    = 16'd1024
) (
  input logic clk125m,
  input logic reset_n,
  udp_sc_frame_mux_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, ENDF, GAP
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  sel_q;
  logic [CW-1:0]  rr_q;
  logic [15:0]    len_q;
  logic [15:0]    sport_q;
  logic [15:0]    dport_q;
  logic [3:0]     idx_q;
  logic [15:0]    cnt_q;
  logic [7:0]     gap_q;
  logic [NCH-1:0] ack_q;
  logic [NCH-1:0] done_q;
  logic [NCH-1:0] err_q;
  logic           wr_q;
  logic [7:0]     data_q;
  logic           dv_q;
  logic           good_q;
`ifdef UDP_SC_TIMEOUT_EN
  logic [15:0]    idle_q;
  logic           bad_q;
`endif

  logic [CW-1:0]  gnt;
  logic           hit;
  int             k;
  logic [NCH-1:0] gnt_oh;
  logic [NCH-1:0] sel_oh;
  logic [15:0]    len_g;
  logic [15:0]    ulen;
  logic [7:0]     hdr_byte;
  logic [7:0]     src_byte;
  logic           rd_v;

  // First requester strictly after the pointer, wrapping.
  always_comb begin
    gnt = rr_q;
    hit = 1'b0;
    k   = 0;
    for (int i = 1; i <= NCH; i++) begin
      k = (int'(rr_q) + i) % NCH;
      if (!hit && bus.src_req[k]) begin
        hit = 1'b1;
        gnt = CW'(k);
      end
    end
  end

  assign gnt_oh   = NCH'(1) << gnt;
  assign sel_oh   = NCH'(1) << sel_q;
  assign len_g    = bus.src_len[16*int'(gnt) +: 16];
  assign src_byte = bus.src_data[8*int'(sel_q) +: 8];
  assign rd_v     = (state_q == DATA) &&
                    bus.src_valid[sel_q] &&
                    !bus.fifo_full;
  assign ulen     = len_q + 16'd8;

  always_comb begin
    case (idx_q)
      4'd0:    hdr_byte = len_q[15:8];
      4'd1:    hdr_byte = len_q[7:0];
      4'd2:    hdr_byte = sport_q[15:8];
      4'd3:    hdr_byte = sport_q[7:0];
      4'd4:    hdr_byte = dport_q[15:8];
      4'd5:    hdr_byte = dport_q[7:0];
      4'd6:    hdr_byte = ulen[15:8];
      4'd7:    hdr_byte = ulen[7:0];
      4'd8:    hdr_byte = UDP_CHKSUM[15:8];
      default: hdr_byte = UDP_CHKSUM[7:0];
    endcase
  end

  always_ff @(posedge clk125m or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= CW'(NCH - 1);
      len_q   <= '0;
      sport_q <= '0;
      dport_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      good_q  <= 1'b0;
`ifdef UDP_SC_TIMEOUT_EN
      idle_q  <= '0;
      bad_q   <= 1'b0;
`endif
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      dv_q   <= 1'b0;
      good_q <= 1'b0;
`ifdef UDP_SC_TIMEOUT_EN
      bad_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (|bus.src_req) begin
            sel_q   <= gnt;
            rr_q    <= gnt;
            len_q   <= len_g;
            sport_q <= bus.src_sport[16*int'(gnt) +: 16];
            dport_q <= bus.src_dport[16*int'(gnt) +: 16];
            idx_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
`ifdef UDP_SC_TIMEOUT_EN
            idle_q  <= '0;
`endif
            if (len_g > MAX_LEN) begin
              err_q   <= gnt_oh;
              state_q <= GAP;
            end else begin
              ack_q   <= gnt_oh;
              wr_q    <= 1'b1;
              state_q <= HDR;
            end
          end
        end
        HDR: begin
          if (!bus.fifo_full) begin
            data_q <= hdr_byte;
            dv_q   <= 1'b1;
            idx_q  <= idx_q + 4'd1;
            if (idx_q == 4'd9)
              state_q <= (len_q == 16'd0) ? ENDF : DATA;
          end
        end
        DATA: begin
          if (rd_v) begin
            data_q <= src_byte;
            dv_q   <= 1'b1;
            cnt_q  <= cnt_q + 16'd1;
`ifdef UDP_SC_TIMEOUT_EN
            idle_q <= '0;
`endif
            if (cnt_q == len_q - 16'd1)
              state_q <= ENDF;
          end
`ifdef UDP_SC_TIMEOUT_EN
          // Only source starvation counts; FIFO stalls never abort.
          else if (!bus.fifo_full) begin
            if (idle_q == TIMEOUT - 16'd1) begin
              bad_q   <= 1'b1;
              err_q   <= sel_oh;
              gap_q   <= '0;
              state_q <= GAP;
            end else begin
              idle_q <= idle_q + 16'd1;
            end
          end
`endif
        end
        ENDF: begin
          good_q  <= 1'b1;
          done_q  <= sel_oh;
          gap_q   <= '0;
          state_q <= GAP;
        end
        GAP: begin
          // wr_en stays up for the cycle carrying the end marker.
          wr_q <= 1'b0;
          if (int'(gap_q) + 1 >= GAP_CYCLES)
            state_q <= IDLE;
          else
            gap_q <= gap_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.src_rd          = rd_v ? sel_oh : '0;
  assign bus.src_ack         = ack_q;
  assign bus.src_done        = done_q;
  assign bus.src_err         = err_q;
  assign bus.fifo_wr_en      = wr_q;
  assign bus.fifo_data       = data_q;
  assign bus.fifo_data_valid = dv_q;
  assign bus.fifo_good_frame = good_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.chan_sel        = sel_q;
`ifdef UDP_SC_TIMEOUT_EN
  assign bus.fifo_bad_frame  = bad_q;
`else
  assign bus.fifo_bad_frame  = 1'b0;
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

endmodule

// File: tb/tb_udp_sc_frame_mux.sv
// tb_udp_sc_frame_mux: directed bench for udp_sc_frame_mux.
// Sources and FIFO modelled behaviourally; expectations hand-computed.
`timescale 1ns/1ps
module tb_udp_sc_frame_mux;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  udp_sc_frame_mux_if #(.NCH(NCH), .CW(CW)) bus();

  udp_sc_frame_mux #(
    .NCH(NCH), .CW(CW),
    .MAX_LEN(16'd1472), .UDP_CHKSUM(16'h0000),
    .GAP_CYCLES(4), .TIMEOUT(16'd16)
  ) dut (
    .clk125m(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  always #4 clk = ~clk;

  logic [7:0]  mem [NCH][8];
  logic [15:0] len_a [NCH];
  logic [15:0] sp_a [NCH];
  logic [15:0] dp_a [NCH];
  int want  [NCH] = '{default: 0};
  int fin   [NCH] = '{default: 0};
  int ptr   [NCH] = '{default: 0};
  int avail [NCH] = '{default: 8};
  logic full_tog = 1'b0;
  logic full     = 1'b0;

  for (genvar c = 0; c < NCH; c++) begin : g_src
    assign bus.src_req[c]          = fin[c] < want[c];
    assign bus.src_len[16*c +: 16]   = len_a[c];
    assign bus.src_sport[16*c +: 16] = sp_a[c];
    assign bus.src_dport[16*c +: 16] = dp_a[c];
    assign bus.src_data[8*c +: 8]    = mem[c][ptr[c][2:0]];
    assign bus.src_valid[c]        = ptr[c] < avail[c];
  end
  assign bus.fifo_full = full;

  // Source FIFO heads advance on pops; requests drop on done/err.
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (bus.src_ack[c]) ptr[c] <= 0;
      else if (bus.src_rd[c]) ptr[c] <= ptr[c] + 1;
      if (bus.src_done[c] | bus.src_err[c]) fin[c] <= fin[c] + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    full = full_tog ? ~full : 1'b0;
  end

  logic [7:0] got[$];
  int gotc[$], gq[$], sq[$], ackc[$], goodc[$];
  int cyc = 0, goods = 0, bads = 0, errtot = 0;
  int err_cyc = 0, bad_cyc = 0, rd_viol = 0, wr_viol = 0;
  int acks [NCH] = '{default: 0};
  int dones [NCH] = '{default: 0};
  int errs [NCH] = '{default: 0};
  int rdcnt [NCH] = '{default: 0};

  always @(negedge clk) begin
    cyc++;
    if (bus.fifo_data_valid) begin
      got.push_back(bus.fifo_data);
      gotc.push_back(cyc);
      if (!bus.fifo_wr_en) wr_viol++;
    end
    if (bus.fifo_good_frame) begin
      goods++;
      goodc.push_back(cyc);
    end
    if (bus.fifo_bad_frame) begin
      bads++;
      bad_cyc = cyc;
    end
    for (int c = 0; c < NCH; c++) begin
      if (bus.src_ack[c]) begin
        acks[c]++;
        gq.push_back(c);
        sq.push_back(int'(bus.chan_sel));
        ackc.push_back(cyc);
      end
      if (bus.src_done[c]) dones[c]++;
      if (bus.src_err[c]) begin
        errs[c]++;
        errtot++;
        err_cyc = cyc;
      end
      if (bus.src_rd[c]) rdcnt[c]++;
    end
    if ((|bus.src_rd) &&
        (bus.fifo_full ||
         bus.src_rd != (4'b0001 << bus.chan_sel)))
      rd_viol++;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int ev();
    return goods + bads + errtot;
  endfunction

  task automatic chk_bytes(input string tag, input int base,
                           input int n, input logic [511:0] v);
    logic [31:0] o;
    for (int i = 0; i < n; i++) begin
      if (base + i < got.size()) o = {24'd0, got[base+i]};
      else o = 'x;
      chk($sformatf("%s[%0d]", tag, i), o,
          {24'd0, v[8*(n-1-i) +: 8]});
    end
    chk({tag, " count"}, got.size() - base, n);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_end(input string tag, input int target,
                          input int budget);
    int n = 0;
    while (!(ev() >= target && !bus.busy) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, " finish"}, 32'(ev() >= target && !bus.busy), 1);
  endtask

  task automatic wait_bytes(input string tag, input int target,
                            input int budget);
    int n = 0;
    while (got.size() < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, " bytes reached"}, 32'(got.size() >= target), 1);
  endtask

  int b, a0, a1, d0, d2, d3, e0, g0, bd0, r0, r2, r3, gi, gci;

  initial begin
    for (int c = 0; c < NCH; c++) begin
      len_a[c] = 16'd0;
      sp_a[c]  = 16'd0;
      dp_a[c]  = 16'd0;
      for (int j = 0; j < 8; j++) mem[c][j] = 8'(16*c + j);
    end

    // Reset state
    tick(2);
    chk("rst wr_en", 32'(bus.fifo_wr_en), 0);
    chk("rst dv", 32'(bus.fifo_data_valid), 0);
    chk("rst good", 32'(bus.fifo_good_frame), 0);
    chk("rst bad", 32'(bus.fifo_bad_frame), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst chan_sel", 32'(bus.chan_sel), 0);
    chk("rst pulses", 32'({bus.src_ack, bus.src_done,
                           bus.src_err, bus.src_rd}), 0);
    rst_n = 1'b1;
    tick(2);

    // T1: ch0 len 3, first grant goes to channel 0
    b = got.size(); a0 = acks[0]; d0 = dones[0];
    g0 = goods; r0 = rdcnt[0];
    len_a[0] = 16'd3; sp_a[0] = 16'h1234; dp_a[0] = 16'h5678;
    mem[0][0] = 8'hA1; mem[0][1] = 8'hA2; mem[0][2] = 8'hA3;
    want[0] = fin[0] + 1;
    wait_end("t1", ev() + 1, 200);
    chk_bytes("t1 byte", b, 13,
              512'(104'h0003_1234_5678_000B_0000_A1A2A3));
    chk("t1 ack0", acks[0] - a0, 1);
    chk("t1 done0", dones[0] - d0, 1);
    chk("t1 good", goods - g0, 1);
    chk("t1 rd0", rdcnt[0] - r0, 3);
    chk("t1 grant", qat(gq, gq.size() - 1), 0);
    chk("t1 good lag",
        qat(goodc, goodc.size() - 1) - qat(gotc, gotc.size() - 1), 1);

    // T2: ch1 and ch3 each hold req for two frames
    b = got.size(); gi = gq.size(); gci = goodc.size();
    len_a[1] = 16'd2; sp_a[1] = 16'h1111; dp_a[1] = 16'h2222;
    len_a[3] = 16'd2; sp_a[3] = 16'h3333; dp_a[3] = 16'h4444;
    mem[1][0] = 8'h11; mem[1][1] = 8'h12;
    mem[3][0] = 8'h31; mem[3][1] = 8'h32;
    want[1] = fin[1] + 2;
    want[3] = fin[3] + 2;
    wait_end("t2", ev() + 4, 400);
    chk("t2 grant0", qat(gq, gi), 1);
    chk("t2 grant1", qat(gq, gi + 1), 3);
    chk("t2 grant2", qat(gq, gi + 2), 1);
    chk("t2 grant3", qat(gq, gi + 3), 3);
    chk("t2 sel0", qat(sq, gi), 1);
    chk("t2 sel1", qat(sq, gi + 1), 3);
    chk("t2 sel2", qat(sq, gi + 2), 1);
    chk("t2 sel3", qat(sq, gi + 3), 3);
    chk_bytes("t2 byte", b, 48, 512'({
      96'h0002_1111_2222_000A_0000_1112,
      96'h0002_3333_4444_000A_0000_3132,
      96'h0002_1111_2222_000A_0000_1112,
      96'h0002_3333_4444_000A_0000_3132}));
    chk("t2 gap", qat(ackc, gi + 1) - qat(goodc, gci), 5);

    // T3: ch2 len 0, header only
    b = got.size(); r2 = rdcnt[2]; d2 = dones[2]; g0 = goods;
    len_a[2] = 16'd0; sp_a[2] = 16'hAAAA; dp_a[2] = 16'h5555;
    want[2] = fin[2] + 1;
    wait_end("t3", ev() + 1, 200);
    chk_bytes("t3 byte", b, 10,
              512'(80'h0000_AAAA_5555_0008_0000));
    chk("t3 rd2", rdcnt[2] - r2, 0);
    chk("t3 done2", dones[2] - d2, 1);
    chk("t3 good", goods - g0, 1);

    // T4: ch3 len 4 with fifo_full toggling
    b = got.size(); r3 = rdcnt[3]; d3 = dones[3];
    len_a[3] = 16'd4; sp_a[3] = 16'h0102; dp_a[3] = 16'h0304;
    mem[3][0] = 8'hD0; mem[3][1] = 8'hD1;
    mem[3][2] = 8'hD2; mem[3][3] = 8'hD3;
    full_tog = 1'b1;
    want[3] = fin[3] + 1;
    wait_end("t4", ev() + 1, 300);
    full_tog = 1'b0;
    tick(1);
    chk_bytes("t4 byte", b, 14,
              512'(112'h0004_0102_0304_000C_0000_D0D1D2D3));
    chk("t4 rd3", rdcnt[3] - r3, 4);
    chk("t4 done3", dones[3] - d3, 1);
    chk("t4 rd legal", rd_viol, 0);
    chk("t4 wr window", wr_viol, 0);

    // T5: ch0 over-length and ch1 together
    b = got.size(); a0 = acks[0]; a1 = acks[1];
    d0 = dones[0]; e0 = errs[0]; gi = ackc.size();
    len_a[0] = 16'd1473; sp_a[0] = 16'h7777; dp_a[0] = 16'h8888;
    len_a[1] = 16'd1; sp_a[1] = 16'h1111; dp_a[1] = 16'h2222;
    mem[1][0] = 8'h11;
    want[0] = fin[0] + 1;
    want[1] = fin[1] + 1;
    wait_end("t5", ev() + 2, 300);
    chk("t5 err0", errs[0] - e0, 1);
    chk("t5 ack0", acks[0] - a0, 0);
    chk("t5 done0", dones[0] - d0, 0);
    chk("t5 ack1", acks[1] - a1, 1);
    chk("t5 gap", qat(ackc, gi) - err_cyc, 5);
    chk_bytes("t5 byte", b, 11,
              512'(88'h0001_1111_2222_0009_0000_11));

`ifdef UDP_SC_TIMEOUT_EN
    // T6: source starves after two bytes
    b = got.size(); e0 = errs[0]; d0 = dones[0];
    g0 = goods; bd0 = bads;
    len_a[0] = 16'd5; sp_a[0] = 16'hABCD; dp_a[0] = 16'h0042;
    mem[0][0] = 8'hA1; mem[0][1] = 8'hA2;
    avail[0] = 2;
    want[0] = fin[0] + 1;
    wait_end("t6", ev() + 1, 300);
    avail[0] = 8;
    chk("t6 bad", bads - bd0, 1);
    chk("t6 good", goods - g0, 0);
    chk("t6 err0", errs[0] - e0, 1);
    chk("t6 done0", dones[0] - d0, 0);
    chk("t6 idle cycles", bad_cyc - qat(gotc, gotc.size() - 1), 16);
    chk_bytes("t6 byte", b, 12,
              512'(96'h0005_ABCD_0042_000D_0000_A1A2));
`endif

    // T7: asynchronous reset mid-DATA on ch3
    b = got.size();
    len_a[3] = 16'd4;
    want[3] = fin[3] + 1;
    wait_bytes("t7", b + 11, 100);
    chk("t7 rd before", 32'(bus.src_rd), 32'h8);
    chk("t7 sel before", 32'(bus.chan_sel), 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7 wr_en", 32'(bus.fifo_wr_en), 0);
    chk("t7 dv", 32'(bus.fifo_data_valid), 0);
    chk("t7 data", 32'(bus.fifo_data), 0);
    chk("t7 busy", 32'(bus.busy), 0);
    chk("t7 chan_sel", 32'(bus.chan_sel), 0);
    chk("t7 rd", 32'(bus.src_rd), 0);
    chk("t7 pulses", 32'({bus.src_ack, bus.src_done, bus.src_err,
                          bus.fifo_good_frame, bus.fifo_bad_frame}), 0);
    want[3] = fin[3];
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("t7 idle after", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/udp_sc_frame_mux.md
Name: udp_sc_frame_mux

Overview:
- N-channel slow-control UDP framer.
- Arbitrates among N slow-control sources round-robin and prefixes each granted payload with a 10-byte length/UDP header.
- Streams header and payload bytes into an 8-bit frame-FIFO write port with good/bad frame marking.
- Successor to the single-channel SC converter: adds channel count, backpressure, length policing, inter-frame gap and abort handling.

Parameters:
- NCH, 4, number of source channels (1..16).
- CW, 2, channel index width, equal to clog2(NCH), minimum 1.
- MAX_LEN, 16'd1472, largest accepted payload length in bytes.
- UDP_CHKSUM, 16'h0000, constant placed in the checksum field.
- GAP_CYCLES, 4, idle cycles enforced after each frame (0..255).
- TIMEOUT, 16'd1024, cycles without source data before abort (used only with the optional feature).

Ports:
- clk125m  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- src_req  in  NCH  per-channel level request; held high until src_done or src_err.
- src_len  in  16*NCH  payload length in bytes; stable while req is high.
- src_sport  in  16*NCH  UDP source port; stable while req is high.
- src_dport  in  16*NCH  UDP destination port; stable while req is high.
- src_data  in  8*NCH  payload byte.
- src_valid  in  NCH  payload byte available.
- src_rd  out  NCH  combinational pop, one-hot to the granted channel.
- src_ack  out  NCH  one-cycle grant pulse.
- src_done  out  NCH  one-cycle completion pulse.
- src_err  out  NCH  one-cycle reject/abort pulse.
- fifo_full  in  1  frame-FIFO backpressure.
- fifo_wr_en  out  1  frame write window.
- fifo_data  out  8  frame byte.
- fifo_data_valid  out  1  byte strobe.
- fifo_good_frame  out  1  end-of-frame, commit.
- fifo_bad_frame  out  1  end-of-frame, discard.
- busy  out  1  state is not IDLE.
- chan_sel  out  CW  currently granted channel.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer = NCH-1, so channel 0 wins first. Reset may assert mid-frame: outputs drop immediately, and the FIFO discards partial data on its own reset.
- States are IDLE, HDR, DATA, END, GAP.
- IDLE:
  - When any src_req is set, grant the first requesting channel after the pointer (wrapping).
  - Latch header fields, set chan_sel and the pointer, and pulse src_ack[g].
  - If src_len > MAX_LEN, pulse src_err[g] instead, write nothing, and go to GAP.
  - Otherwise go to HDR with fifo_wr_en=1.
- Header: 10 bytes, MSB first: len[15:8], len[7:0], sport, dport, udp_len = len+8 (16-bit, computed before the MAX_LEN check, no wrap since MAX_LEN ≤ 65527), UDP_CHKSUM.
- HDR:
  - Each cycle with fifo_full=0, emit the next byte with fifo_data_valid=1. With fifo_full=1, data_valid=0 and the header does not advance.
  - After byte 10, go to DATA, or go to END if len==0.
- DATA:
  - src_rd[g] = (state==DATA) & src_valid[g] & ~fifo_full.
  - On a pop, fifo_data <= src_data[g] and data_valid <= 1 (registered, 1-cycle latency); otherwise data_valid <= 0.
  - A 16-bit counter counts pops. The pop where count==len-1 moves to END.
- END: fifo_good_frame=1 for one cycle, src_done[g]=1, fifo_wr_en stays 1. Then go to GAP.
- GAP:
  - fifo_wr_en=0; hold GAP_CYCLES cycles, then IDLE (GAP_CYCLES=0 passes through in one cycle).
  - A channel still holding req is regranted only after the other requesters.
- src_valid on non-granted channels is ignored. src_req dropping mid-frame is ignored; the frame completes.
- The arbiter is not re-evaluated until IDLE. Simultaneous requests resolve strictly round-robin.

Optional Feature:
- Macro: UDP_SC_TIMEOUT_EN.
- Defined:
  - In DATA, a 16-bit idle counter increments on each cycle without a pop while fifo_full=0, and clears on a pop.
  - Reaching TIMEOUT drives fifo_bad_frame=1 for one cycle (in place of good_frame) and src_err[g]=1, no src_done, then GAP.
  - Stalls caused by fifo_full never time out.
- Undefined: no counter is built; fifo_bad_frame is tied 0 and DATA waits indefinitely.

Test Plan:
- Ch0 req, len=3, sport=0x1234, dport=0x5678, data A1 A2 A3 always valid → ack0 pulse; FIFO bytes 00 03 12 34 56 78 00 0B 00 00 A1 A2 A3; good_frame one cycle after A3; done0; 4 gap cycles.
- Ch1 and ch3 req simultaneously, both held for two frames → grant order 1,3,1,3; chan_sel matches; no frame interleaving.
- Ch2 len=0 → exactly 10 header bytes (udp_len=0x0008), then good_frame; src_rd never asserted.
- fifo_full toggling every other cycle during a len=4 frame → byte sequence intact, no duplicated or lost bytes; src_rd only when full=0.
- Ch0 len=1473 → src_err0 pulse, no fifo_data_valid, no ack; next requester granted after the gap.
- With UDP_SC_TIMEOUT_EN and TIMEOUT=16, len=5, src_valid dropped after 2 bytes → bad_frame at idle cycle 16, err0 pulse. Separately, reset_n low mid-DATA → all outputs 0 asynchronously.
